instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/commit controller that produces everything the 8-bit ALU consumes.
- Drives ALU SELECT, the operand-mux controls, register-file addresses and write enable.
- Fetches 32-bit instructions from instruction memory over a read/busywait handshake.
- Owns the PC and resolves j/beq using the ALU ZERO flag.
- Sits between instruction memory and the datapath (reg file, negation mux, immediate mux, alu).

---
 rtl/instr_sequencer_pkg.sv | 82 ++++++++
 rtl/instr_sequencer_if.sv | 31 +++
 rtl/instr_sequencer_pc_next_unit.sv | 18 +
 rtl/instr_sequencer.sv | 97 +++++++++
 tb/tb_instr_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU SELECT codes,
// FSM states and the opcode decoder.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        EXEC   = 2'b01,
        COMMIT = 2'b10
    } seq_state_e;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    // Same encodings as the alu SELECT mux.
    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef struct packed {
        logic [2:0] aluop;
        logic       neg_sel;
        logic       imm_sel;
        logic       reg_write;
        logic       is_jump;
        logic       is_beq;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [7:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_LOADI: begin
                c.aluop     = ALU_FWD;
                c.imm_sel   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_MOV: begin
                c.aluop     = ALU_FWD;
                c.reg_write = 1'b1;
            end
            OP_ADD: begin
                c.aluop     = ALU_ADD;
                c.reg_write = 1'b1;
            end
            OP_SUB: begin
                c.aluop     = ALU_ADD;
                c.neg_sel   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_AND: begin
                c.aluop     = ALU_AND;
                c.reg_write = 1'b1;
            end
            OP_OR: begin
                c.aluop     = ALU_OR;
                c.reg_write = 1'b1;
            end
            OP_J: begin
                c.is_jump = 1'b1;
            end
            OP_BEQ: begin
                // beq compares by subtracting, ZERO comes back from the alu
                c.aluop   = ALU_ADD;
                c.neg_sel = 1'b1;
                c.is_beq  = 1'b1;
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the sequencer, instruction memory and the 8-bit datapath.
interface instr_sequencer_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                INSTR_BUSYWAIT;
    logic [31:0]         INSTRUCTION;
    logic                ALU_ZERO;
    logic                INSTR_READ;
    logic [PC_WIDTH-1:0] PC;
    logic [2:0]          ALUOP;
    logic                NEG_SEL;
    logic                IMM_SEL;
    logic [7:0]          IMMEDIATE;
    logic [2:0]          READREG1;
    logic [2:0]          READREG2;
    logic [2:0]          WRITEREG;
    logic                WRITEENABLE;
    logic                ILLEGAL;

    modport master (
        input  INSTR_BUSYWAIT, INSTRUCTION, ALU_ZERO,
        output INSTR_READ, PC, ALUOP, NEG_SEL, IMM_SEL, IMMEDIATE,
               READREG1, READREG2, WRITEREG, WRITEENABLE, ILLEGAL
    );

    modport slave (
        output INSTR_BUSYWAIT, INSTRUCTION, ALU_ZERO,
        input  INSTR_READ, PC, ALUOP, NEG_SEL, IMM_SEL, IMMEDIATE,
               READREG1, READREG2, WRITEREG, WRITEENABLE, ILLEGAL
    );
endinterface

// File: rtl/instr_sequencer_pc_next_unit.sv
// Next-PC candidates: sequential PC and PC-relative branch target (word offset).
module pc_next_unit #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [7:0]          offset,
    output logic [PC_WIDTH-1:0] pc_seq,
    output logic [PC_WIDTH-1:0] pc_branch
);
    logic [PC_WIDTH-1:0] offset_ext;

    always_comb begin
        pc_seq     = pc + PC_WIDTH'(PC_STEP);
        offset_ext = {{(PC_WIDTH-8){offset[7]}}, offset};
        pc_branch  = pc_seq + (offset_ext << 2);
    end
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/exec/commit controller driving the 8-bit datapath and owning the PC.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    instr_sequencer_if.master    bus
);
    seq_state_e          state;
    logic [PC_WIDTH-1:0] pc_q;
    logic                read_q;
    ctrl_t               ctrl_q;
    logic [7:0]          off_q;
    logic [2:0]          rt_q;
    logic [7:0]          imm_q;
    logic                we_q;
    logic                ill_q;
    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] pc_branch;
    logic                rt_hi_unused;

    assign rt_hi_unused = ^bus.INSTRUCTION[15:11];

    pc_next_unit #(
        .PC_WIDTH(PC_WIDTH),
        .PC_STEP (PC_STEP)
    ) u_pc_next (
        .pc       (pc_q),
        .offset   (off_q),
        .pc_seq   (pc_seq),
        .pc_branch(pc_branch)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= FETCH;
            pc_q   <= '0;
            read_q <= 1'b0;
            ctrl_q <= '0;
            off_q  <= '0;
            rt_q   <= '0;
            imm_q  <= '0;
            we_q   <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    we_q   <= 1'b0;
                    ill_q  <= 1'b0;
                    read_q <= 1'b1;
                    if (read_q && !bus.INSTR_BUSYWAIT) begin
                        ctrl_q <= decode_op(bus.INSTRUCTION[31:24]);
                        off_q  <= bus.INSTRUCTION[23:16];
                        rt_q   <= bus.INSTRUCTION[10:8];
                        imm_q  <= bus.INSTRUCTION[7:0];
                        read_q <= 1'b0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    we_q  <= ctrl_q.reg_write;
                    ill_q <= ctrl_q.illegal;
                    state <= COMMIT;
                end
                COMMIT: begin
                    we_q   <= 1'b0;
                    ill_q  <= 1'b0;
                    read_q <= 1'b1;
                    if (ctrl_q.is_jump || (ctrl_q.is_beq && bus.ALU_ZERO))
                        pc_q <= pc_branch;
                    else
                        pc_q <= pc_seq;
                    state <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign bus.INSTR_READ = read_q;
    assign bus.PC         = pc_q;
    assign bus.ALUOP      = ctrl_q.aluop;
    assign bus.NEG_SEL    = ctrl_q.neg_sel;
    assign bus.IMM_SEL    = ctrl_q.imm_sel;
    assign bus.IMMEDIATE  = imm_q;
    assign bus.READREG1   = rt_q;
    assign bus.READREG2   = imm_q[2:0];
    assign bus.WRITEREG   = off_q[2:0];
    // Reset arriving during COMMIT must suppress the strobes already registered for that cycle.
    assign bus.WRITEENABLE = we_q & ~RESET;
    assign bus.ILLEGAL     = ill_q & ~RESET;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: driver models the PC, monitor checks decode and strobes.
module tb_instr_sequencer;
    logic CLK = 1'b0;
    logic RESET;

    instr_sequencer_if #(.PC_WIDTH(32)) bus ();

    instr_sequencer #(
        .PC_WIDTH(32),
        .PC_STEP (4)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // {aluop[2:0], neg_sel, imm_sel, writes_reg} straight from the opcode table
    function automatic logic [5:0] ref_ctrl(input logic [7:0] op);
        case (op)
            8'h00:   return 6'b000_0_1_1;
            8'h01:   return 6'b000_0_0_1;
            8'h02:   return 6'b001_0_0_1;
            8'h03:   return 6'b001_1_0_1;
            8'h04:   return 6'b010_0_0_1;
            8'h05:   return 6'b011_0_0_1;
            8'h06:   return 6'b000_0_0_0;
            8'h07:   return 6'b001_1_0_0;
            default: return 6'b000_0_0_0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    bit          mon_en = 1'b0;
    int unsigned k = 3;
    logic [31:0] model_pc;

    // Monitor: an accept pops the next expectation; the following cycles are EXEC, COMMIT, idle FETCH.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (bus.INSTR_READ && !bus.INSTR_BUSYWAIT) begin
                check("accept_expected", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    cur = expq.pop_front();
                    check("fetch_pc", bus.PC, cur.pc);
                end
                k = 0;
            end else begin
                logic [5:0] want;
                logic [7:0] op;
                k = (k < 3) ? k + 1 : 3;
                op = cur.instr[31:24];
                want = ref_ctrl(op);
                if (k == 1 || k == 2) begin
                    check("read_low", bus.INSTR_READ, 0);
                    check("decode", {bus.ALUOP, bus.NEG_SEL, bus.IMM_SEL}, want[5:1]);
                    check("fields", {bus.IMMEDIATE, bus.READREG1, bus.READREG2, bus.WRITEREG},
                          {cur.instr[7:0], cur.instr[10:8], cur.instr[2:0], cur.instr[18:16]});
                end
                if (k == 1) begin
                    check("exec_we", bus.WRITEENABLE, 0);
                    check("exec_illegal", bus.ILLEGAL, 0);
                end else if (k == 2) begin
                    check("commit_we", bus.WRITEENABLE, want[0]);
                    check("commit_illegal", bus.ILLEGAL, 32'(op > 8'h07));
                end else begin
                    check("fetch_read", bus.INSTR_READ, 1);
                    check("idle_we", bus.WRITEENABLE, 0);
                    check("idle_illegal", bus.ILLEGAL, 0);
                end
            end
        end
    end

    task automatic wait_read();
        int unsigned t = 0;
        @(negedge CLK);
        while (!bus.INSTR_READ && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check("read_within_budget", bus.INSTR_READ, 1);
    endtask

    task automatic issue(input logic [31:0] ins, input logic z, input int unsigned busy);
        int off;
        wait_read();
        @(posedge CLK); #1;
        bus.INSTRUCTION = ins;
        bus.ALU_ZERO    = z;
        expq.push_back('{pc: model_pc, instr: ins});
        off = $signed(ins[23:16]);
        if (ins[31:24] == 8'h06 || (ins[31:24] == 8'h07 && z))
            model_pc = model_pc + 32'd4 + 32'(off * 4);
        else
            model_pc = model_pc + 32'd4;
        repeat (busy) begin
            @(posedge CLK); #1;
        end
        bus.INSTR_BUSYWAIT = 1'b0;
        @(posedge CLK); #1;
        bus.INSTR_BUSYWAIT = 1'b1;
        bus.INSTRUCTION    = $urandom;
    endtask

    task automatic reset_in_commit(input logic [31:0] ins);
        wait_read();
        @(posedge CLK); #1;
        bus.INSTRUCTION    = ins;
        bus.INSTR_BUSYWAIT = 1'b0;
        @(posedge CLK); #1;
        bus.INSTR_BUSYWAIT = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_commit_we", bus.WRITEENABLE, 0);
        check("rst_commit_illegal", bus.ILLEGAL, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_commit_pc", bus.PC, 0);
        check("rst_commit_read", bus.INSTR_READ, 0);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  op;

        RESET              = 1'b1;
        bus.INSTR_BUSYWAIT = 1'b0;
        bus.INSTRUCTION    = 32'h0100_0000;
        bus.ALU_ZERO       = 1'b0;

        @(posedge CLK);
        @(negedge CLK);
        check("reset_read", bus.INSTR_READ, 0);
        check("reset_pc", bus.PC, 0);
        check("reset_outputs", {bus.ALUOP, bus.NEG_SEL, bus.IMM_SEL, bus.IMMEDIATE, bus.READREG1,
                                bus.READREG2, bus.WRITEREG, bus.WRITEENABLE, bus.ILLEGAL}, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("first_fetch_read", bus.INSTR_READ, 1);
        check("first_fetch_pc", bus.PC, 0);
        @(negedge CLK);
        bus.INSTR_BUSYWAIT = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("three_cycle_pc", bus.PC, 32'h4);
        check("three_cycle_read", bus.INSTR_READ, 1);

        model_pc = 32'h4;
        k        = 3;
        mon_en   = 1'b1;

        issue(32'h06FD_0000, 1'b0, 0);   // j from 0x4 to 0xFFFFFFFC
        issue(32'h0601_0000, 1'b0, 0);   // j wraps to 0x4
        issue(32'h0005_002A, 1'b0, 3);   // loadi r5, 0x2A with stalls
        issue(32'h0303_0102, 1'b0, 0);   // sub r3, r1, r2
        issue(32'h0204_0506, 1'b0, 0);
        issue(32'h07FE_0102, 1'b1, 0);   // beq at 0x10, taken
        issue(32'h0106_0700, 1'b0, 0);
        issue(32'h07FE_0102, 1'b0, 0);   // beq at 0x10, not taken
        issue(32'hFF00_0000, 1'b0, 0);   // undefined opcode

        for (int i = 0; i < 150; i++) begin
            r = $urandom;
            if ($urandom_range(0, 9) < 9)
                op = 8'($urandom_range(0, 7));
            else
                op = 8'($urandom_range(8, 255));
            issue({op, r[23:0]}, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        wait_read();
        repeat (30) @(negedge CLK);
        check("stall_pc", bus.PC, model_pc);
        check("stall_read", bus.INSTR_READ, 1);
        check("queue_drained", expq.size(), 0);
        mon_en = 1'b0;

        reset_in_commit(32'hFF00_0000);

        wait_read();
        @(posedge CLK); #1;
        RESET              = 1'b1;
        bus.INSTR_BUSYWAIT = 1'b0;
        bus.INSTRUCTION    = 32'h0207_0605;
        @(posedge CLK); #1;
        bus.INSTR_BUSYWAIT = 1'b1;
        @(negedge CLK);
        check("rst_fetch_read", bus.INSTR_READ, 0);
        check("rst_fetch_pc", bus.PC, 0);
        check("rst_fetch_no_latch", {bus.IMMEDIATE, bus.READREG1, bus.READREG2, bus.WRITEREG, bus.ALUOP}, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        reset_in_commit(32'h0207_0605);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end, n_vec=%0d", n_vec);
        $fatal(1);
    end
endmodule
